// File: rtl/frame_payload_extractor_pkg.sv
// Shared frame geometry and FSM state encoding for the payload extractor.
//   FRAME_LEN / HDR_LEN / PAYLOAD_LEN : frame layout in bytes
//   POS_W                              : width of the byte-position field
//   FIRST_PAYLOAD_POS / LAST_PAYLOAD_POS : payload position window
//   state_e                            : extractor FSM states
package frame_payload_extractor_pkg;

  localparam int FRAME_LEN         = 12;
  localparam int HDR_LEN           = 2;
  localparam int PAYLOAD_LEN       = 10;
  localparam int POS_W             = 4;
  localparam int FIRST_PAYLOAD_POS = HDR_LEN;
  localparam int LAST_PAYLOAD_POS  = FRAME_LEN - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

endpackage

// File: rtl/frame_payload_extractor_fifo.sv
// fa_payload_fifo: payload byte store with speculative writes.
// Bytes land at the speculative pointer; only bytes below the committed
// pointer are visible to the reader. A commit publishes everything written
// so far (including a write in the same cycle); a rollback forgets all
// uncommitted bytes.
// Ports:
//   clk, reset        clock, async active-low reset
//   wr_en, wr_data    speculative write of a 9-bit entry {last, byte}
//   commit, rollback  publish / discard uncommitted entries
//   rd_en             pop head when rd_valid
//   rd_data, rd_valid head entry and committed-occupancy-nonzero flag
//   free_space        DEPTH minus (speculative write pointer - read pointer)
module fa_payload_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [8:0]  wr_data,
  input  logic        commit,
  input  logic        rollback,
  input  logic        rd_en,
  output logic [8:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] free_space
);

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_spec_q, wr_spec_d;
  logic [AW:0] wr_com_q,  wr_com_d;
  logic [AW:0] rd_q,      rd_d;

  assign rd_valid   = (wr_com_q != rd_q);
  assign rd_data    = mem_q[rd_q[AW-1:0]];
  assign free_space = (AW+1)'(DEPTH) - (wr_spec_q - rd_q);

  always_comb begin
    wr_spec_d = wr_spec_q;
    wr_com_d  = wr_com_q;
    rd_d      = rd_q;
    if (rollback)   wr_spec_d = wr_com_q;
    else if (wr_en) wr_spec_d = wr_spec_q + (AW+1)'(1);
    // Commit takes the post-write pointer so the final byte is included.
    if (commit)     wr_com_d  = wr_spec_d;
    if (rd_en && rd_valid) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_spec_q <= '0;
      wr_com_q  <= '0;
      rd_q      <= '0;
    end else begin
      wr_spec_q <= wr_spec_d;
      wr_com_q  <= wr_com_d;
      rd_q      <= rd_d;
    end
  end

  // Storage needs no reset: nothing is readable until committed.
  always_ff @(posedge clk) begin
    if (wr_en && !rollback) mem_q[wr_spec_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_payload_extractor.sv
// Extracts the 10 payload bytes of each aligned frame into a FIFO, exposing
// a frame only once all of its payload has arrived in sequence.
// Ports:
//   clk, reset                 clock, async active-low reset
//   rx_data, frame_detect,
//   fr_byte_position           byte stream and alignment info from the aligner
//   out_data, out_valid,
//   out_ready, out_last        payload stream, out_last on the 10th byte
//   frames_ok, frames_dropped  saturating frame counters
//
// state      | meaning
// ST_IDLE    | waiting for payload position 2 of a locked frame
// ST_COLLECT | writing payload speculatively, expecting position prev+1
// ST_DROP    | frame rejected for lack of space, skipping to its end
module frame_payload_extractor
  import frame_payload_extractor_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             frame_detect,
  input  logic [POS_W-1:0] fr_byte_position,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 16");
  end

  state_e           state_q, state_d;
  logic [POS_W-1:0] prev_pos_q, prev_pos_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic        wr_en, commit, rollback;
  logic [8:0]  head;
  logic        head_valid;
  logic [AW:0] free_space;
  logic        is_payload, is_first, is_last, in_seq;

  assign is_payload = frame_detect
                   && (fr_byte_position >= POS_W'(FIRST_PAYLOAD_POS))
                   && (fr_byte_position <= POS_W'(LAST_PAYLOAD_POS));
  assign is_first   = is_payload && (fr_byte_position == POS_W'(FIRST_PAYLOAD_POS));
  assign is_last    = fr_byte_position == POS_W'(LAST_PAYLOAD_POS);
  assign in_seq     = is_payload && (fr_byte_position == prev_pos_q + POS_W'(1));

  always_comb begin
    state_d    = state_q;
    prev_pos_d = prev_pos_q;
    ok_d       = ok_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_first) begin
          // In IDLE the speculative pointer equals the committed one, so
          // free_space is exactly the room available for a whole payload.
          if (free_space >= (AW+1)'(PAYLOAD_LEN)) begin
            state_d    = ST_COLLECT;
            wr_en      = 1'b1;
            prev_pos_d = fr_byte_position;
          end else begin
            state_d = ST_DROP;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (in_seq) begin
          wr_en      = 1'b1;
          prev_pos_d = fr_byte_position;
          if (is_last) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
            if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
          end
        end else begin
          rollback = 1'b1;
          state_d  = ST_IDLE;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
      end
      ST_DROP: begin
        if (!frame_detect || is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      prev_pos_q <= '0;
      ok_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_pos_q <= prev_pos_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  fa_payload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    ({is_last, rx_data}),
    .commit     (commit),
    .rollback   (rollback),
    .rd_en      (out_ready),
    .rd_data    (head),
    .rd_valid   (head_valid),
    .free_space (free_space)
  );

  // Head is gated so unwritten storage never shows through when empty.
  assign out_valid      = head_valid;
  assign out_data       = head_valid ? head[7:0] : 8'h00;
  assign out_last       = head_valid & head[8];
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_q;

endmodule

// File: doc/frame_payload_extractor.md
FRAME_PAYLOAD_EXTRACTOR -- requirements
Module: frame_payload_extractor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, payload byte capacity; power of two, minimum 16.
REQ-002 SHALL have parameter CNT_W, default 16, width of frame counters.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8, byte stream from the frame aligner.
REQ-006 SHALL have port frame_detect, input, 1, aligner lock indication, same cycle as rx_data.
REQ-007 SHALL have port fr_byte_position, input, 4, position of current rx_data byte in frame (0-1 header, 2-11 payload).
REQ-008 SHALL have port out_data, output, 8, payload byte.
REQ-009 SHALL have port out_valid, output, 1, out_data/out_last valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts byte.
REQ-011 SHALL have port out_last, output, 1, marks the 10th payload byte of a frame.
REQ-012 SHALL have port frames_ok, output, CNT_W, committed frame count.
REQ-013 SHALL have port frames_dropped, output, CNT_W, aborted or dropped frame count.

Function
REQ-014 SHALL sample inputs each cycle; a byte is a payload byte only when frame_detect=1 and fr_byte_position in 2..11.
REQ-015 SHALL implement FSM IDLE, COLLECT, DROP; reset state IDLE.
REQ-016 IDLE: on frame_detect=1 and position 2, SHALL go to COLLECT and write the byte if free space >= 10, else go to DROP and increment frames_dropped.
REQ-017 COLLECT: each cycle with frame_detect=1 and position = previous+1 SHALL write the byte speculatively; out_last bit stored =1 only at position 11.
REQ-018 COLLECT at position 11 SHALL commit all 10 bytes (committed write pointer := speculative), increment frames_ok, return to IDLE.
REQ-019 COLLECT with frame_detect=0 or non-sequential position SHALL discard the partial frame (speculative pointer := committed), increment frames_dropped, return to IDLE; the aborting byte is not written.
REQ-020 DROP SHALL write nothing and return to IDLE on position 11 or frame_detect=0.
REQ-021 Free space SHALL be FIFO_DEPTH minus (speculative write pointer - read pointer), using pointers one bit wider than the address.
REQ-022 out_valid SHALL be 1 whenever committed occupancy > 0; uncommitted bytes never visible.
REQ-023 A byte transfers when out_valid and out_ready are both 1; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Latency: first byte of a frame SHALL appear on out_valid the cycle after the position-11 byte is sampled.
REQ-025 Simultaneous read and commit/write SHALL both take effect in the same cycle.
REQ-026 frames_ok and frames_dropped SHALL saturate at all-ones.
REQ-027 out_data SHALL be read combinationally from the FIFO head (no extra output register).

Reset
REQ-028 reset low SHALL asynchronously set FSM to IDLE, all pointers to 0, out_valid=0, out_last=0, out_data=0, frames_ok=0, frames_dropped=0.
REQ-029 reset asserted mid-frame SHALL discard all buffered bytes, committed or not; no counter increment.
REQ-030 Outputs SHALL be deterministic from the first rising edge after reset release.

Structure
REQ-031 Shared RTL package SHALL hold FRAME_LEN=12, HDR_LEN=2, PAYLOAD_LEN=10, POS_W=4, and the FSM state enum.
REQ-032 SHALL instantiate one sub-module fa_payload_fifo: storage of 9-bit entries, speculative/committed write pointers, commit and rollback inputs, free-space output.

Verification
REQ-033 Three good frames with payload 0x01..0x0A, out_ready=1 -> 30 bytes in order, out_last on each 0x0A, frames_ok=3, frames_dropped=0.
REQ-034 frame_detect drops at position 6 -> no bytes of that frame output, frames_dropped=1; next good frame output intact.
REQ-035 out_ready=0 until 3 frames committed (30 bytes, FIFO_DEPTH=32) -> 4th frame dropped (free=2), frames_dropped=1; draining yields exactly 30 bytes.
REQ-036 out_ready toggled every cycle during back-to-back frames -> no loss, no duplication, out_data stable while stalled.
REQ-037 reset asserted at position 8 of frame 2 after frame 1 committed and unread -> out_valid=0 immediately, counters 0, frame 3 after release output normally.
REQ-038 Position sequence 2,3,5 with frame_detect=1 -> abort at 5, frames_dropped=1, no bytes output.
